ahb_bridge_arbiter: RTL and testbench

Three-master AHB arbiter placed in front of the AHB-to-APB bridge top level so that three AHB masters can share its single AHB slave port. It samples per-master bus requests and grants the bridge to one master at a time using round-robin priority, with a beat cap per tenure. It multiplexes the owner's address-phase signals and the data-phase owner's write data onto the bridge inputs, and tracks the AHB address/data pipeline so write data follows the correct master across a handover.

---
 rtl/ahb_bridge_arbiter.sv | 155 +++++++++++++++
 tb/tb_ahb_bridge_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_bridge_arbiter.sv
// Three-master round-robin AHB arbiter in front of the AHB-to-APB bridge.
// Ports: Hclk/Hresetn; per-master Hbusreq, Htrans*, Haddr*, Hwrite*, Hwdata*;
//   bridge ready Hreadyout_b; outputs Hgrant, Hmaster, Hmaster_d, muxed
//   *_b bridge inputs, and ready copies Hreadyin_b / Hready_m.
module ahb_bridge_arbiter #(
   parameter int MAX_BEATS = 4,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic          Hclk,
   input  logic          Hresetn,
   input  logic [2:0]    Hbusreq,
   input  logic [1:0]    Htrans0,
   input  logic [1:0]    Htrans1,
   input  logic [1:0]    Htrans2,
   input  logic [AW-1:0] Haddr0,
   input  logic [AW-1:0] Haddr1,
   input  logic [AW-1:0] Haddr2,
   input  logic          Hwrite0,
   input  logic          Hwrite1,
   input  logic          Hwrite2,
   input  logic [DW-1:0] Hwdata0,
   input  logic [DW-1:0] Hwdata1,
   input  logic [DW-1:0] Hwdata2,
   input  logic          Hreadyout_b,
   output logic [2:0]    Hgrant,
   output logic [1:0]    Hmaster,
   output logic [1:0]    Hmaster_d,
   output logic [1:0]    Htrans_b,
   output logic [AW-1:0] Haddr_b,
   output logic          Hwrite_b,
   output logic [DW-1:0] Hwdata_b,
   output logic          Hreadyin_b,
   output logic          Hready_m
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OWNED = 1'b1;
   localparam logic [3:0] CAP   = 4'(MAX_BEATS - 1);

   logic [0:0] state;
   logic [1:0] last;
   logic [3:0] beat_cnt;

   logic       owner_req;
   logic       beat;
   logic [2:0] others;
   logic [1:0] pick_any;
   logic [1:0] pick_other;
   logic       change;
   logic       go_idle;
   logic [1:0] new_idx;

   function automatic logic [1:0] nxt(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Search order base+1, base+2, base; falls back to base when empty.
   function automatic logic [1:0] rr_pick(input logic [1:0] base,
                                          input logic [2:0] req);
      logic [1:0] i1;
      logic [1:0] i2;
      i1 = nxt(base);
      i2 = nxt(i1);
      if (req[i1])      return i1;
      else if (req[i2]) return i2;
      else              return base;
   endfunction

   assign Hreadyin_b = Hreadyout_b;
   assign Hready_m   = Hreadyout_b;

   // Address-phase mux, forced to an IDLE transfer when nobody owns the bus.
   always_comb begin
      Htrans_b = 2'b00;
      Haddr_b  = '0;
      Hwrite_b = 1'b0;
      if (state == OWNED) begin
         unique case (Hmaster)
            2'd0: begin
               Htrans_b = Htrans0;
               Haddr_b  = Haddr0;
               Hwrite_b = Hwrite0;
            end
            2'd1: begin
               Htrans_b = Htrans1;
               Haddr_b  = Haddr1;
               Hwrite_b = Hwrite1;
            end
            default: begin
               Htrans_b = Htrans2;
               Haddr_b  = Haddr2;
               Hwrite_b = Hwrite2;
            end
         endcase
      end
   end

   // Write data follows the data-phase owner, one accepted beat behind.
   always_comb begin
      unique case (Hmaster_d)
         2'd1:    Hwdata_b = Hwdata1;
         2'd2:    Hwdata_b = Hwdata2;
         default: Hwdata_b = Hwdata0;
      endcase
   end

   assign owner_req  = Hbusreq[Hmaster];
   assign beat       = Hreadyout_b && (state == OWNED) && Htrans_b[1];
   assign others     = Hbusreq & ~Hgrant;
   assign pick_any   = rr_pick(last, Hbusreq);
   assign pick_other = rr_pick(last, others);

   always_comb begin
      change  = 1'b0;
      go_idle = 1'b0;
      new_idx = pick_any;
      if (state == IDLE) begin
         change = |Hbusreq;
      end else if (!owner_req) begin
         change  = |Hbusreq;
         go_idle = ~|Hbusreq;
      end else if (beat && beat_cnt == CAP && |others) begin
         change  = 1'b1;
         new_idx = pick_other;
      end
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= IDLE;
         Hgrant    <= 3'b000;
         Hmaster   <= 2'd0;
         Hmaster_d <= 2'd0;
         last      <= 2'd2;
         beat_cnt  <= 4'd0;
      end else if (Hreadyout_b) begin
         Hmaster_d <= Hmaster;
         if (go_idle) begin
            state    <= IDLE;
            Hgrant   <= 3'b000;
            beat_cnt <= 4'd0;
         end else if (change) begin
            state    <= OWNED;
            Hgrant   <= 3'b001 << new_idx;
            Hmaster  <= new_idx;
            last     <= new_idx;
            beat_cnt <= 4'd0;
         end else if (beat && beat_cnt != CAP) begin
            beat_cnt <= beat_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter (MAX_BEATS=4).
// Expected grant/owner state is queued per step and compared after the edge.
module tb_ahb_bridge_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   localparam logic [AW-1:0] A0 = 32'h1000_0000;
   localparam logic [AW-1:0] A1 = 32'h2000_0004;
   localparam logic [AW-1:0] A2 = 32'h3000_0008;
   localparam logic [DW-1:0] W0 = 32'hAAAA_0000;
   localparam logic [DW-1:0] W1 = 32'hBBBB_1111;
   localparam logic [DW-1:0] W2 = 32'hCCCC_2222;

   logic          Hclk = 1'b0;
   logic          Hresetn = 1'b0;
   logic [2:0]    Hbusreq = 3'b000;
   logic [1:0]    Htrans0 = 2'b00;
   logic [1:0]    Htrans1 = 2'b00;
   logic [1:0]    Htrans2 = 2'b00;
   logic [AW-1:0] Haddr0 = A0;
   logic [AW-1:0] Haddr1 = A1;
   logic [AW-1:0] Haddr2 = A2;
   logic          Hwrite0 = 1'b1;
   logic          Hwrite1 = 1'b0;
   logic          Hwrite2 = 1'b1;
   logic [DW-1:0] Hwdata0 = W0;
   logic [DW-1:0] Hwdata1 = W1;
   logic [DW-1:0] Hwdata2 = W2;
   logic          Hreadyout_b = 1'b1;
   logic [2:0]    Hgrant;
   logic [1:0]    Hmaster;
   logic [1:0]    Hmaster_d;
   logic [1:0]    Htrans_b;
   logic [AW-1:0] Haddr_b;
   logic          Hwrite_b;
   logic [DW-1:0] Hwdata_b;
   logic          Hreadyin_b;
   logic          Hready_m;

   ahb_bridge_arbiter #(.MAX_BEATS(4), .AW(AW), .DW(DW)) dut (
      .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq),
      .Htrans0(Htrans0), .Htrans1(Htrans1), .Htrans2(Htrans2),
      .Haddr0(Haddr0), .Haddr1(Haddr1), .Haddr2(Haddr2),
      .Hwrite0(Hwrite0), .Hwrite1(Hwrite1), .Hwrite2(Hwrite2),
      .Hwdata0(Hwdata0), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
      .Hreadyout_b(Hreadyout_b),
      .Hgrant(Hgrant), .Hmaster(Hmaster), .Hmaster_d(Hmaster_d),
      .Htrans_b(Htrans_b), .Haddr_b(Haddr_b), .Hwrite_b(Hwrite_b),
      .Hwdata_b(Hwdata_b), .Hreadyin_b(Hreadyin_b), .Hready_m(Hready_m)
   );

   always #5 Hclk = ~Hclk;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      string      tag;
      logic [2:0] g;
      logic [1:0] m;
      logic [1:0] md;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Queue the expected state, advance one edge, then compare.
   task automatic step(input string tag, input logic [2:0] g,
                       input logic [1:0] m, input logic [1:0] md);
      exp_t e;
      sb.push_back('{tag, g, m, md});
      @(posedge Hclk);
      #1;
      e = sb.pop_front();
      check({e.tag, "_gnt"}, 64'(Hgrant), 64'(e.g));
      check({e.tag, "_mst"}, 64'(Hmaster), 64'(e.m));
      check({e.tag, "_mstd"}, 64'(Hmaster_d), 64'(e.md));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      check("rst_gnt", 64'(Hgrant), 64'd0);
      check("rst_mst", 64'(Hmaster), 64'd0);
      check("rst_mstd", 64'(Hmaster_d), 64'd0);
      check("rst_trans", 64'(Htrans_b), 64'd0);
      check("rst_addr", 64'(Haddr_b), 64'd0);
      check("rst_wdata", 64'(Hwdata_b), 64'(W0));
      check("rst_cnt", 64'(dut.beat_cnt), 64'd0);
      @(posedge Hclk);
      #1;
      Hresetn = 1'b1;
      Hbusreq = 3'b111;
      Htrans0 = 2'b10;
      step("first", 3'b001, 2'd0, 2'd0);
      check("first_trans", 64'(Htrans_b), 64'd2);
      check("first_addr", 64'(Haddr_b), 64'(A0));
      check("first_wr", 64'(Hwrite_b), 64'd1);

      Hbusreq = 3'b011;
      step("cap1", 3'b001, 2'd0, 2'd0);
      Htrans0 = 2'b11;
      step("cap2", 3'b001, 2'd0, 2'd0);
      step("cap3", 3'b001, 2'd0, 2'd0);
      Htrans1 = 2'b10;
      step("cap4", 3'b010, 2'd1, 2'd0);
      check("cap4_wdata", 64'(Hwdata_b), 64'(W0));
      step("cap5", 3'b010, 2'd1, 2'd1);
      check("cap5_wdata", 64'(Hwdata_b), 64'(W1));
      check("cap5_trans", 64'(Htrans_b), 64'd2);
      check("cap5_addr", 64'(Haddr_b), 64'(A1));
      check("cap5_wr", 64'(Hwrite_b), 64'd0);

      Hbusreq = 3'b101;
      Htrans2 = 2'b10;
      step("rel1", 3'b100, 2'd2, 2'd1);
      check("rel1_addr", 64'(Haddr_b), 64'(A2));
      Hbusreq = 3'b001;
      Htrans0 = 2'b10;
      step("rel2", 3'b001, 2'd0, 2'd2);
      check("rel2_wdata", 64'(Hwdata_b), 64'(W2));

      Hbusreq = 3'b011;
      for (int i = 0; i < 3; i++)
         step("wbeat", 3'b001, 2'd0, 2'd0);
      check("wbeat_cnt", 64'(dut.beat_cnt), 64'd3);
      Hreadyout_b = 1'b0;
      #1;
      check("rdy_m", 64'(Hready_m), 64'd0);
      check("rdy_in", 64'(Hreadyin_b), 64'd0);
      for (int i = 0; i < 3; i++)
         step("stall", 3'b001, 2'd0, 2'd0);
      check("stall_cnt", 64'(dut.beat_cnt), 64'd3);
      Hreadyout_b = 1'b1;
      step("w_go", 3'b010, 2'd1, 2'd0);
      check("w_go_cnt", 64'(dut.beat_cnt), 64'd0);

      Hbusreq = 3'b100;
      step("sole0", 3'b100, 2'd2, 2'd1);
      for (int i = 0; i < 10; i++)
         step("sole", 3'b100, 2'd2, 2'd2);
      check("sole_cnt", 64'(dut.beat_cnt), 64'd3);
      Hbusreq = 3'b101;
      Htrans2 = 2'b00;
      step("sole_nobeat", 3'b100, 2'd2, 2'd2);
      Htrans2 = 2'b11;
      step("sole_ho", 3'b001, 2'd0, 2'd2);

      Hbusreq = 3'b001;
      Htrans0 = 2'b10;
      step("burst", 3'b001, 2'd0, 2'd0);
      check("burst_trans", 64'(Htrans_b), 64'd2);
      check("burst_wr", 64'(Hwrite_b), 64'd1);
      #2;
      Hresetn = 1'b0;
      #1;
      check("mrst_gnt", 64'(Hgrant), 64'd0);
      check("mrst_trans", 64'(Htrans_b), 64'd0);
      check("mrst_wr", 64'(Hwrite_b), 64'd0);
      check("mrst_addr", 64'(Haddr_b), 64'd0);
      step("in_rst", 3'b000, 2'd0, 2'd0);
      Hresetn = 1'b1;
      Hbusreq = 3'b100;
      Htrans2 = 2'b10;
      step("after_rst", 3'b100, 2'd2, 2'd0);
      check("after_rst_addr", 64'(Haddr_b), 64'(A2));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
